mmio_arbiter: RTL and testbench
===============================

MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 SHALL have parameters: AWIDTH, 16, MMIO word-address width; MAX_LOCK, 8, max consecutive grants one locked requester may hold (1..255).
REQ-002 SHALL have ports (name  direction  width  meaning):
  clk  in  1  single clock, all state on rising edge
  reset  in  1  reset, asynchronous, active-low
  REQ0/REQ1  in  1  access request; held until granted
  LOCK0/LOCK1  in  1  keep ownership after this grant (read-modify-write sequences)
  ADDR0/ADDR1  in  AWIDTH  word address
  WEA0/WEA1  in  4  byte write enables; 4'b0 = read
  WDATA0/WDATA1  in  32  write data
  GNT0/GNT1  out  1  request issued to MMIO this cycle
  RVALID0/RVALID1  out  1  read data valid
  RDATA0/RDATA1  out  32  read data
  MMIO_EN  out  1  MMIO access strobe
  MMIO_ADDR  out  AWIDTH  MMIO word address
  MMIO_WEA  out  4  MMIO byte enables
  MMIO_DIN  out  32  MMIO write data
  MMIO_DOUT  in  32  MMIO read data, valid one cycle after a read strobe

Function
REQ-003 SHALL issue at most one access per cycle; winner's ADDR/WEA/WDATA drive MMIO_* combinationally, with MMIO_EN=1 and GNTx=1 in the same cycle.
REQ-004 With no grant, MMIO_EN, MMIO_WEA and both GNT SHALL be 0; MMIO_ADDR and MMIO_DIN SHALL be 0.
REQ-005 FSM states IDLE, OWN0, OWN1; reset state IDLE.
REQ-006 In IDLE, a single asserted REQ SHALL win; if both assert, the requester not granted most recently SHALL win (round-robin pointer, reset value favours requester 0).
REQ-007 The pointer SHALL update on every grant to mark the winner as last-granted.
REQ-008 IDLE->OWNx when x is granted with LOCKx=1; the lock counter SHALL load 1.
REQ-009 In OWNx only requester x SHALL be granted, even if REQx=0 and the other REQ=1. Each grant to x SHALL increment the counter.
REQ-010 OWNx->IDLE when LOCKx=0, or when a grant brings the counter to MAX_LOCK. On limit exit the other requester SHALL have priority at the next IDLE arbitration.
REQ-011 In OWNx with REQx=0 and LOCKx=1, the state SHALL be held and no access issued.
REQ-012 A read grant in cycle N (WEA=0) SHALL assert RVALIDx for exactly cycle N+1 with RDATAx=MMIO_DOUT. The read-owner tag SHALL be a registered 1-cycle flag per requester.
REQ-013 Write grants SHALL produce no RVALID. Back-to-back reads from alternating requesters SHALL each receive their own RVALID in the following cycle.
REQ-014 RDATAx SHALL be 0 when RVALIDx=0.
REQ-015 Read latency SHALL be 1 cycle; grant latency from REQ SHALL be 0 cycles when uncontended.

Reset
REQ-016 Asserting reset (low) SHALL asynchronously clear: FSM to IDLE, pointer to favour requester 0, lock counter to 0, RVALID flags to 0.
REQ-017 Reset asserted mid-lock or mid-read SHALL drop ownership and any pending RVALID; no RVALID SHALL appear after reset deasserts.

Structure
REQ-018 The FSM state encoding and the requester-count constant (2) SHALL live in a shared package.
REQ-019 The round-robin winner select SHALL be one sub-module, rr_pick2, with inputs req[1:0] and last, and output onehot grant[1:0].

Verification
REQ-020 Single read: REQ0=1, ADDR0=0x0010, WEA0=0 -> GNT0 and MMIO_EN in the same cycle, MMIO_ADDR=0x0010; next cycle RVALID0=1 and RDATA0=MMIO_DOUT (0xDEADBEEF).
REQ-021 Contention: REQ0 and REQ1 held high for 4 cycles, no LOCK -> grant order 0,1,0,1.
REQ-022 Lock limit: MAX_LOCK=8, LOCK0=REQ0=1, REQ1=1 -> GNT0 for 8 cycles, then GNT1 in the 9th cycle.
REQ-023 Lock hold with idle owner: in OWN0 with REQ0=0, LOCK0=1, REQ1=1 -> no GNT1 and MMIO_EN=0 until LOCK0 falls.
REQ-024 Write: REQ1=1, WEA1=4'b0011, WDATA1=0x12345678 -> MMIO_WEA=4'b0011, MMIO_DIN=0x12345678, no RVALID1 in the following cycle.
REQ-025 Reset mid-read: reset low in the cycle after a read grant -> RVALID0=0 immediately, FSM in IDLE, and a following REQ1-only request is granted.

Source files
------------

// File: rtl/mmio_arbiter_pkg.sv
// rtl/mmio_arbiter_pkg.sv - shared FSM encoding and requester count for the MMIO arbiter
package mmio_arbiter_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin winner select, onehot grant
module rr_pick2
    import mmio_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic [NUM_REQ-1:0] grant
);

    // On contention the requester that did not win most recently takes the slot.
    always_comb begin
        grant = '0;
        if (req[0] && req[1]) begin
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/mmio_arbiter.sv
// rtl/mmio_arbiter.sv - two-requester MMIO arbiter with round-robin, bounded lock and 1-cycle read return
module mmio_arbiter
    import mmio_arbiter_pkg::*;
#(
    parameter int AWIDTH   = 16,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              LOCK0,
    input  logic              LOCK1,
    input  logic [AWIDTH-1:0] ADDR0,
    input  logic [AWIDTH-1:0] ADDR1,
    input  logic [3:0]        WEA0,
    input  logic [3:0]        WEA1,
    input  logic [31:0]       WDATA0,
    input  logic [31:0]       WDATA1,
    output logic              GNT0,
    output logic              GNT1,
    output logic              RVALID0,
    output logic              RVALID1,
    output logic [31:0]       RDATA0,
    output logic [31:0]       RDATA1,
    output logic              MMIO_EN,
    output logic [AWIDTH-1:0] MMIO_ADDR,
    output logic [3:0]        MMIO_WEA,
    output logic [31:0]       MMIO_DIN,
    input  logic [31:0]       MMIO_DOUT
);

    localparam logic [7:0] LOCK_LIM = 8'(MAX_LOCK);

    state_t             state;
    logic               last;
    logic [7:0]         lock_cnt;
    logic               rv0;
    logic               rv1;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] gnt;

    rr_pick2 u_pick (
        .req   ({REQ1, REQ0}),
        .last  (last),
        .grant (pick)
    );

    // An owner may be granted even while the other side is requesting.
    always_comb begin
        gnt = '0;
        case (state)
            IDLE:    gnt = pick;
            OWN0:    gnt = {1'b0, REQ0};
            OWN1:    gnt = {REQ1, 1'b0};
            default: gnt = '0;
        endcase
    end

    assign GNT0 = gnt[0];
    assign GNT1 = gnt[1];

    always_comb begin
        MMIO_EN   = |gnt;
        MMIO_ADDR = '0;
        MMIO_WEA  = '0;
        MMIO_DIN  = '0;
        if (gnt[0]) begin
            MMIO_ADDR = ADDR0;
            MMIO_WEA  = WEA0;
            MMIO_DIN  = WDATA0;
        end else if (gnt[1]) begin
            MMIO_ADDR = ADDR1;
            MMIO_WEA  = WEA1;
            MMIO_DIN  = WDATA1;
        end
    end

    assign RVALID0 = rv0;
    assign RVALID1 = rv1;
    assign RDATA0  = rv0 ? MMIO_DOUT : 32'd0;
    assign RDATA1  = rv1 ? MMIO_DOUT : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            lock_cnt <= 8'd0;
            rv0      <= 1'b0;
            rv1      <= 1'b0;
        end else begin
            rv0 <= gnt[0] && (WEA0 == 4'b0000);
            rv1 <= gnt[1] && (WEA1 == 4'b0000);
            if (|gnt) begin
                last <= gnt[1];
            end
            case (state)
                IDLE: begin
                    if (gnt[0] && LOCK0 && (LOCK_LIM > 8'd1)) begin
                        state    <= OWN0;
                        lock_cnt <= 8'd1;
                    end else if (gnt[1] && LOCK1 && (LOCK_LIM > 8'd1)) begin
                        state    <= OWN1;
                        lock_cnt <= 8'd1;
                    end
                end
                OWN0: begin
                    if (!LOCK0 || (gnt[0] && (lock_cnt + 8'd1 == LOCK_LIM))) begin
                        state    <= IDLE;
                        lock_cnt <= 8'd0;
                    end else if (gnt[0]) begin
                        lock_cnt <= lock_cnt + 8'd1;
                    end
                end
                OWN1: begin
                    if (!LOCK1 || (gnt[1] && (lock_cnt + 8'd1 == LOCK_LIM))) begin
                        state    <= IDLE;
                        lock_cnt <= 8'd0;
                    end else if (gnt[1]) begin
                        lock_cnt <= lock_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    lock_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_arbiter.sv
// tb/tb_mmio_arbiter.sv - self-checking bench for mmio_arbiter with a behavioural reference model
module tb_mmio_arbiter;

    localparam int AWIDTH   = 16;
    localparam int MAX_LOCK = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              REQ0, REQ1, LOCK0, LOCK1;
    logic [AWIDTH-1:0] ADDR0, ADDR1;
    logic [3:0]        WEA0, WEA1;
    logic [31:0]       WDATA0, WDATA1;
    logic              GNT0, GNT1, RVALID0, RVALID1;
    logic [31:0]       RDATA0, RDATA1;
    logic              MMIO_EN;
    logic [AWIDTH-1:0] MMIO_ADDR;
    logic [3:0]        MMIO_WEA;
    logic [31:0]       MMIO_DIN;
    logic [31:0]       MMIO_DOUT;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the bus, how many locked grants so far,
    // who won last, and which requesters are owed read data next cycle.
    int   m_owner = -1;
    int   m_cnt   = 0;
    int   m_last  = 1;
    logic [1:0] m_rv = 2'b00;

    mmio_arbiter #(.AWIDTH(AWIDTH), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset),
        .REQ0(REQ0), .REQ1(REQ1), .LOCK0(LOCK0), .LOCK1(LOCK1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WEA0(WEA0), .WEA1(WEA1),
        .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
        .RDATA0(RDATA0), .RDATA1(RDATA1),
        .MMIO_EN(MMIO_EN), .MMIO_ADDR(MMIO_ADDR), .MMIO_WEA(MMIO_WEA),
        .MMIO_DIN(MMIO_DIN), .MMIO_DOUT(MMIO_DOUT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        logic [1:0] r;
        int w;
        logic [3:0] wea_w;
        r = {REQ1, REQ0};
        if (!reset) begin
            m_owner = -1;
            m_cnt   = 0;
            m_last  = 1;
            m_rv    = 2'b00;
        end
        chk("m_rvalid0", RVALID0, m_rv[0]);
        chk("m_rvalid1", RVALID1, m_rv[1]);
        chk("m_rdata0", RDATA0, m_rv[0] ? MMIO_DOUT : 32'd0);
        chk("m_rdata1", RDATA1, m_rv[1] ? MMIO_DOUT : 32'd0);

        if (m_owner < 0) begin
            if (r == 2'b11)      w = 1 - m_last;
            else if (r[0])       w = 0;
            else if (r[1])       w = 1;
            else                 w = -1;
        end else begin
            w = r[m_owner] ? m_owner : -1;
        end
        wea_w = (w == 0) ? WEA0 : (w == 1) ? WEA1 : 4'd0;

        chk("m_gnt0", GNT0, w == 0);
        chk("m_gnt1", GNT1, w == 1);
        chk("m_en", MMIO_EN, w >= 0);
        chk("m_addr", MMIO_ADDR, (w == 0) ? ADDR0 : (w == 1) ? ADDR1 : '0);
        chk("m_wea", MMIO_WEA, wea_w);
        chk("m_din", MMIO_DIN, (w == 0) ? WDATA0 : (w == 1) ? WDATA1 : 32'd0);

        if (reset) begin
            m_rv = 2'b00;
            if (w >= 0) begin
                m_rv[w] = (wea_w == 4'd0);
                m_last  = w;
            end
            if (m_owner < 0) begin
                if (w >= 0 && ((w == 0) ? LOCK0 : LOCK1) && MAX_LOCK > 1) begin
                    m_owner = w;
                    m_cnt   = 1;
                end
            end else begin
                if (w >= 0) m_cnt++;
                if (!((m_owner == 0) ? LOCK0 : LOCK1) || m_cnt == MAX_LOCK) begin
                    m_owner = -1;
                    m_cnt   = 0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        #2;
        model_compare();
    end

    task automatic idle_inputs();
        REQ0 = 0; REQ1 = 0; LOCK0 = 0; LOCK1 = 0;
        ADDR0 = '0; ADDR1 = '0; WEA0 = '0; WEA1 = '0;
        WDATA0 = '0; WDATA1 = '0;
    endtask

    initial begin
        int ord[4];
        ord = '{0, 1, 0, 1};
        reset = 1'b0;
        MMIO_DOUT = 32'h0;
        idle_inputs();
        @(negedge clk);
        #1;
        chk("reset_rvalid0", RVALID0, 1'b0);
        chk("reset_en", MMIO_EN, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Contention from reset: requester 0 favoured first.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            REQ0 = 1; REQ1 = 1;
            #1;
            chk("contention_gnt0", GNT0, ord[i] == 0);
            chk("contention_gnt1", GNT1, ord[i] == 1);
        end
        @(negedge clk); idle_inputs();

        // Single read.
        @(negedge clk);
        REQ0 = 1; ADDR0 = 16'h0010; WEA0 = 4'b0;
        #1;
        chk("read_gnt0", GNT0, 1'b1);
        chk("read_en", MMIO_EN, 1'b1);
        chk("read_addr", MMIO_ADDR, 16'h0010);
        @(negedge clk);
        idle_inputs(); MMIO_DOUT = 32'hDEADBEEF;
        #1;
        chk("read_rvalid0", RVALID0, 1'b1);
        chk("read_rdata0", RDATA0, 32'hDEADBEEF);

        // Write from requester 1.
        @(negedge clk);
        REQ1 = 1; WEA1 = 4'b0011; WDATA1 = 32'h12345678;
        #1;
        chk("write_gnt1", GNT1, 1'b1);
        chk("write_wea", MMIO_WEA, 4'b0011);
        chk("write_din", MMIO_DIN, 32'h12345678);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("write_no_rvalid1", RVALID1, 1'b0);

        // Lock limit: eight grants to 0, then 1 takes the ninth.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            REQ0 = 1; LOCK0 = 1; REQ1 = 1;
            #1;
            chk("lock_gnt0", GNT0, i < 8);
            chk("lock_gnt1", GNT1, i == 8);
        end
        @(negedge clk); idle_inputs();

        // Lock hold with idle owner.
        @(negedge clk);
        REQ0 = 1; LOCK0 = 1;
        #1;
        chk("hold_take_gnt0", GNT0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            REQ0 = 0; LOCK0 = 1; REQ1 = 1;
            #1;
            chk("hold_gnt1", GNT1, 1'b0);
            chk("hold_en", MMIO_EN, 1'b0);
        end
        @(negedge clk);
        LOCK0 = 0; REQ1 = 1;
        #1;
        chk("hold_release_gnt1", GNT1, 1'b0);
        @(negedge clk);
        REQ1 = 1;
        #1;
        chk("after_release_gnt1", GNT1, 1'b1);
        @(negedge clk); idle_inputs();

        // Randomised traffic, checked by the model every cycle.
        repeat (800) begin
            @(negedge clk);
            REQ0   = ($urandom_range(99) < 60);
            REQ1   = ($urandom_range(99) < 60);
            LOCK0  = ($urandom_range(99) < 30);
            LOCK1  = ($urandom_range(99) < 30);
            ADDR0  = AWIDTH'($urandom);
            ADDR1  = AWIDTH'($urandom);
            WEA0   = $urandom_range(1) ? 4'd0 : 4'($urandom);
            WEA1   = $urandom_range(1) ? 4'd0 : 4'($urandom);
            WDATA0 = $urandom;
            WDATA1 = $urandom;
            MMIO_DOUT = $urandom;
        end
        @(negedge clk); idle_inputs();
        @(negedge clk);

        // Reset mid-read and mid-lock.
        @(negedge clk);
        REQ0 = 1; LOCK0 = 1; WEA0 = 4'b0; ADDR0 = 16'h0044;
        #1;
        chk("rst_read_gnt0", GNT0, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_rvalid0_async", RVALID0, 1'b0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        REQ1 = 1; WEA1 = 4'hF; WDATA1 = 32'hA5A5A5A5;
        #1;
        chk("rst_after_gnt1", GNT1, 1'b1);
        chk("rst_after_gnt0", GNT0, 1'b0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("rst_after_rvalid0", RVALID0, 1'b0);
        chk("rst_after_rvalid1", RVALID1, 1'b0);
        @(negedge clk);
        #3;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
